button_debounce_edge: RTL and testbench
=======================================

Name: button_debounce_edge

Overview:
- Conditions a raw, asynchronous, bouncing push-button or switch signal into a clean, clock-synchronous level.
- Also produces single-cycle rise/fall pulses and a press counter.
- Sits directly upstream of the lab's D flip-flops, registers and counters: its `level` or `rise` output drives their D/enable inputs.
- Board inputs therefore never reach flip-flop D pins unsynchronised or bouncing.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flip-flops on btn_in; legal range 2..4.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a new level (10 ms at 50 MHz); legal range >= 2.
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 0, 1 = button pulls input low when pressed (input is inverted after synchronisation).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- btn_in  input  1  raw asynchronous button/switch input.
- cnt_clr  input  1  synchronous clear of press_count.
- level  output  1  debounced, active-high button state.
- rise  output  1  one-cycle pulse on debounced 0->1.
- fall  output  1  one-cycle pulse on debounced 1->0.
- press_count  output  8  number of accepted presses, wraps modulo 256.

Behaviour:
- Reset (async, immediate):
  - Synchroniser flops load the idle level (ACTIVE_LOW ? 1 : 0), so no false press appears after reset.
  - FSM goes to S_LOW; debounce counter = 0.
  - Outputs: level = 0, rise = 0, fall = 0, press_count = 0.
- Synchroniser: btn_in passes through SYNC_STAGES flops in series. Signal s = last stage XOR ACTIVE_LOW.
- FSM states: S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW. Counter cnt is CNT_W bits. One transition per clock edge.
  - S_LOW: if s==1 -> S_CHK_HIGH, cnt<=1; else stay, cnt<=0.
  - S_CHK_HIGH:
    - s==0 -> S_LOW, cnt<=0 (bounce rejected, no pulse).
    - s==1 and cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, cnt<=0, level<=1, rise<=1.
    - Otherwise cnt<=cnt+1.
  - S_HIGH: if s==0 -> S_CHK_LOW, cnt<=1; else stay.
  - S_CHK_LOW: mirror of S_CHK_HIGH.
    - s==1 -> S_HIGH (no pulse).
    - s==0 and cnt==DEBOUNCE_CYCLES-1 -> S_LOW, level<=0, fall<=1.
- Acceptance rule: a new level is accepted at the edge where s has been sampled at its new value on DEBOUNCE_CYCLES consecutive edges.
- Latency: for a clean btn_in step just before edge 1, level changes at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Outputs: level, rise and fall are registered. rise/fall are high for exactly one cycle and clear on the next edge. rise and fall are never high together.
- press_count:
  - Increments by 1 on the edge that sets rise; 255 -> 0 wrap, no saturation.
  - cnt_clr==1 at an edge -> press_count<=0. Clear wins over a simultaneous increment (result 0).
  - cnt_clr has no effect on the FSM or level.
- Any glitch shorter than DEBOUNCE_CYCLES samples produces no output change.
- Reset asserted mid-check or mid-press: immediate return to reset values. A press in progress is not counted, and no pulse is produced on reset.
- The debounce counter never exceeds DEBOUNCE_CYCLES-1; no wrap is possible.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=0 unless stated.
- Clean press: btn_in 0->1 before edge 1, held -> level=1 after edge 6; rise=1 only between edges 6 and 7; press_count=1.
- Bounce rejection: btn_in high for 3 cycles, low 1, high 3, then low -> level stays 0, rise never asserts, press_count=0.
- Clean release after press: btn_in 1->0 held -> level=0 exactly 6 edges after the change; fall one cycle; press_count unchanged.
- Wrap and clear:
  - 256 clean presses -> press_count=0 after the 256th rise.
  - Next press -> 1.
  - cnt_clr=1 on the same edge as a rise -> press_count=0.
- Reset mid-operation: assert rst while in S_CHK_HIGH (cnt=2) -> level/rise/fall/press_count=0 immediately without a clock edge. After release with btn_in still high, a full 6-edge acceptance is required.
- ACTIVE_LOW=1: hold btn_in=1 through reset release -> level stays 0; drive btn_in=0 -> level=1 after 6 edges; rise pulses once.

Source files
------------

// File: rtl/button_debounce_edge.sv
// rtl/button_debounce_edge.sv - button synchroniser, debouncer, edge pulses and press counter
module button_debounce_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       cnt_clr,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        S_LOW,
        S_CHK_HIGH,
        S_HIGH,
        S_CHK_LOW
    } state_t;

    localparam logic             P_IDLE = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] P_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic [7:0]             r_press_count;

    state_t                 w_next_state;
    logic [CNT_W-1:0]       w_next_cnt;
    logic                   w_next_level;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_s;

    // Synchroniser idles at the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{P_IDLE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1] ^ P_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_level <= w_next_level;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        w_next_level = r_level;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        case (r_state)
            S_LOW: begin
                if (w_s) begin
                    w_next_state = S_CHK_HIGH;
                    w_next_cnt   = P_ONE;
                end
            end
            S_CHK_HIGH: begin
                if (!w_s) begin
                    w_next_state = S_LOW;
                end else if (r_cnt == P_LAST) begin
                    w_next_state = S_HIGH;
                    w_next_level = 1'b1;
                    w_rise       = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + P_ONE;
                end
            end
            S_HIGH: begin
                if (!w_s) begin
                    w_next_state = S_CHK_LOW;
                    w_next_cnt   = P_ONE;
                end
            end
            S_CHK_LOW: begin
                if (w_s) begin
                    w_next_state = S_HIGH;
                end else if (r_cnt == P_LAST) begin
                    w_next_state = S_LOW;
                    w_next_level = 1'b0;
                    w_fall       = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + P_ONE;
                end
            end
            default: begin
                w_next_state = S_LOW;
                w_next_level = 1'b0;
            end
        endcase
    end

    // Clear has priority over a press accepted on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press_count <= 8'd0;
        end else if (cnt_clr) begin
            r_press_count <= 8'd0;
        end else if (w_rise) begin
            r_press_count <= r_press_count + 8'd1;
        end
    end

    assign level       = r_level;
    assign rise        = r_rise;
    assign fall        = r_fall;
    assign press_count = r_press_count;

endmodule

// File: tb/tb_button_debounce_edge.sv
// tb/tb_button_debounce_edge.sv - scoreboard bench for button_debounce_edge
module tb_button_debounce_edge;

    logic       clk = 1'b0;
    logic       rst, rst_al;
    logic       btn, btn_al;
    logic       cnt_clr, cnt_clr_al;
    logic       level, rise, fall;
    logic       level_al, rise_al, fall_al;
    logic [7:0] cnt, cnt_al;

    int checks = 0;
    int errors = 0;
    int rise_seen = 0;
    int rise_seen_al = 0;

    typedef struct {
        string      tag;
        bit         al;
        logic [10:0] exp;
    } sb_item_t;

    sb_item_t sb[$];

    always #5 clk = ~clk;

    button_debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .btn_in(btn), .cnt_clr(cnt_clr),
        .level(level), .rise(rise), .fall(fall), .press_count(cnt)
    );

    button_debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst_al), .btn_in(btn_al), .cnt_clr(cnt_clr_al),
        .level(level_al), .rise(rise_al), .fall(fall_al), .press_count(cnt_al)
    );

    always @(negedge clk) begin
        if (rise) rise_seen++;
        if (rise_al) rise_seen_al++;
        checks++;
        assert (!((rise && fall) || (rise_al && fall_al))) else begin
            errors++;
            $error("FAIL rise_fall_exclusive: observed rise=%b fall=%b rise_al=%b fall_al=%b expected never both high",
                   rise, fall, rise_al, fall_al);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input bit al, input logic lvl, input logic r,
                              input logic f, input logic [7:0] c);
        sb_item_t it;
        it.tag = tag;
        it.al  = al;
        it.exp = {lvl, r, f, c};
        sb.push_back(it);
    endtask

    task automatic check_pop();
        sb_item_t    it;
        logic [10:0] obs;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed no entry expected an entry");
        end else begin
            it  = sb.pop_front();
            obs = it.al ? {level_al, rise_al, fall_al, cnt_al} : {level, rise, fall, cnt};
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s: observed lvl/rise/fall/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                       it.tag, obs[10], obs[9], obs[8], obs[7:0],
                       it.exp[10], it.exp[9], it.exp[8], it.exp[7:0]);
            end
        end
    endtask

    task automatic step(input int n, input string tag, input logic lvl, input logic r,
                        input logic f, input logic [7:0] c);
        expect_out(tag, 1'b0, lvl, r, f, c);
        tick(n);
        check_pop();
    endtask

    task automatic press_cycle();
        btn = 1'b1;
        tick(7);
        btn = 1'b0;
        tick(7);
    endtask

    initial begin
        rst = 1'b1; rst_al = 1'b1;
        btn = 1'b0; btn_al = 1'b1;
        cnt_clr = 1'b0; cnt_clr_al = 1'b0;
        #1;
        expect_out("reset_main", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0); check_pop();
        expect_out("reset_al", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); check_pop();
        tick(2);
        rst = 1'b0;

        // Bounce: 3 high, 1 low, 3 high, then low
        rise_seen = 0;
        btn = 1'b1; tick(3);
        btn = 1'b0; tick(1);
        btn = 1'b1; tick(3);
        btn = 1'b0;
        step(8, "bounce_reject", 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        assert (rise_seen == 0) else begin
            errors++;
            $error("FAIL bounce_no_rise: observed %0d rise pulses expected 0", rise_seen);
        end

        // Clean press
        btn = 1'b1;
        step(5, "press_before_accept", 1'b0, 1'b0, 1'b0, 8'd0);
        step(1, "press_accept_edge6", 1'b1, 1'b1, 1'b0, 8'd1);
        step(1, "press_rise_clears", 1'b1, 1'b0, 1'b0, 8'd1);

        // Clean release
        btn = 1'b0;
        step(5, "release_before_accept", 1'b1, 1'b0, 1'b0, 8'd1);
        step(1, "release_accept_edge6", 1'b0, 1'b0, 1'b1, 8'd1);
        step(1, "release_fall_clears", 1'b0, 1'b0, 1'b0, 8'd1);

        // Wrap
        for (int i = 0; i < 254; i++) press_cycle();
        step(0, "count_255", 1'b0, 1'b0, 1'b0, 8'd255);
        btn = 1'b1;
        step(6, "wrap_to_0", 1'b1, 1'b1, 1'b0, 8'd0);
        btn = 1'b0; tick(7);
        btn = 1'b1;
        step(6, "after_wrap_1", 1'b1, 1'b1, 1'b0, 8'd1);
        btn = 1'b0; tick(7);

        // Clear on the same edge as a rise
        btn = 1'b1;
        tick(5);
        cnt_clr = 1'b1;
        step(1, "clear_beats_rise", 1'b1, 1'b1, 1'b0, 8'd0);
        cnt_clr = 1'b0;
        btn = 1'b0; tick(7);

        press_cycle();
        step(0, "press_after_clear", 1'b0, 1'b0, 1'b0, 8'd1);
        cnt_clr = 1'b1;
        step(1, "clear_idle", 1'b0, 1'b0, 1'b0, 8'd0);
        cnt_clr = 1'b0;
        press_cycle();

        // Reset while in S_CHK_HIGH with cnt=2
        btn = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        expect_out("reset_mid_check", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0); check_pop();
        rst = 1'b0;
        #1;
        step(5, "post_reset_wait", 1'b0, 1'b0, 1'b0, 8'd0);
        step(1, "post_reset_accept", 1'b1, 1'b1, 1'b0, 8'd1);
        btn = 1'b0; tick(7);

        // Active-low instance: idle high through reset release
        rise_seen_al = 0;
        rst_al = 1'b0;
        expect_out("al_idle_high", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); tick(8); check_pop();
        btn_al = 1'b0;
        expect_out("al_before_accept", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); tick(5); check_pop();
        expect_out("al_accept_edge6", 1'b1, 1'b1, 1'b1, 1'b0, 8'd1); tick(1); check_pop();
        expect_out("al_rise_clears", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1); tick(1); check_pop();
        tick(4);
        checks++;
        assert (rise_seen_al == 1) else begin
            errors++;
            $error("FAIL al_single_rise: observed %0d rise pulses expected 1", rise_seen_al);
        end

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
